// File: rtl/uart_receiver_pkg.sv
// ============================================================================
// uart_receiver_pkg : shared FSM encodings and oversampling constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_receiver_pkg;

  localparam int         C_OVERSAMPLE = 16;
  localparam logic [3:0] C_MID_TICK   = 4'd7;
  localparam logic [3:0] C_LAST_TICK  = 4'(C_OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/uart_receiver_baud_gen.sv
// ============================================================================
// rx_baud_gen : one-clk oversample tick every CLOCK_FREQ/(BAUD_RATE*16) clks
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_baud_gen
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int C_DIV_RAW = CLOCK_FREQ / (BAUD_RATE * C_OVERSAMPLE);
  localparam int C_DIV     = (C_DIV_RAW < 1) ? 1 : C_DIV_RAW;
  localparam int C_CW      = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_DIV - 1);

  logic [C_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver : 16x-oversampled 8N1 UART receiver with valid/ready output
// Optional even parity bit when UART_RX_PARITY_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       parity_error
);

  logic       r_sync1;
  logic       r_sync2;
  logic       w_rx;
  logic       w_tick;
  logic [2:0] r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_armed;
  logic       w_done;

  rx_baud_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_done = w_tick && (r_state == S_STOP) && (r_tick_cnt == C_LAST_TICK)
                  && w_rx && !r_par_bad;
`else
  assign w_done = w_tick && (r_state == S_STOP) && (r_tick_cnt == C_LAST_TICK) && w_rx;
  assign parity_error = 1'b0;
`endif

  // r_armed stays low after a framing error until the line is seen high,
  // so a held break produces a single error instead of a stream of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_armed     <= 1'b1;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            r_tick_cnt <= 4'd0;
            if (w_rx) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= S_START;
            end
          end
          S_START: begin
            if (r_tick_cnt == C_MID_TICK) begin
              r_tick_cnt <= 4'd0;
              r_bit_cnt  <= 3'd0;
              r_state    <= w_rx ? S_IDLE : S_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == C_LAST_TICK) begin
              r_shift[r_bit_cnt] <= w_rx;
              r_bit_cnt          <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == C_LAST_TICK) begin
              r_par_bad    <= ^{r_shift, w_rx};
              parity_error <= ^{r_shift, w_rx};
              r_state      <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            if (r_tick_cnt == C_LAST_TICK) begin
              r_state <= S_IDLE;
              if (!w_rx) begin
                frame_error <= 1'b1;
                r_armed     <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // A completing byte may reload the holding register on the very clk the
  // consumer takes the old one; only an unaccepted old byte blocks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (w_done) begin
        if (rx_valid && !rx_ready) begin
          overrun_error <= 1'b1;
        end else begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// tb_uart_receiver : scoreboard bench, random + directed frames at 16 clk/bit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int BIT_CLKS   = 16;
  localparam int K_DATA     = 0;
  localparam int K_FRAME    = 1;
  localparam int K_OVR      = 2;
  localparam int K_PAR      = 3;
`ifdef UART_RX_PARITY_EN
  localparam int EXTRA_CLKS = BIT_CLKS;
`else
  localparam int EXTRA_CLKS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun_error;
  logic       parity_error;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  last_pres_cyc = 0;
  bit  model_full = 1'b0;

  uart_receiver #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end

  function automatic string kname(int k);
    case (k)
      K_DATA:  return "data";
      K_FRAME: return "frame_error";
      K_OVR:   return "overrun_error";
      default: return "parity_error";
    endcase
  endfunction

  function automatic void push_ev(int k, logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic observe(int k, logic [7:0] d);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s 0x%02h, expected no event", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == K_DATA && e.data !== d)) begin
        n_fail++;
        $display("FAIL event: got %s 0x%02h, expected %s 0x%02h",
                 kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  // Monitor: a byte is presented when valid rises or reloads after a handshake.
  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
      end else begin
        if (parity_error)  observe(K_PAR, 8'h00);
        if (frame_error)   observe(K_FRAME, 8'h00);
        if (overrun_error) observe(K_OVR, 8'h00);
        if (rx_valid && (!pv || pr)) begin
          observe(K_DATA, rx_data);
          last_pres_cyc = cyc;
        end else if (pv && !pr) begin
          n_tests++;
          if (!rx_valid || rx_data !== pd) begin
            n_fail++;
            $display("FAIL hold: got valid=%0b data=0x%02h, expected valid=1 data=0x%02h",
                     rx_valid, rx_data, pd);
          end
        end
        pv = rx_valid;
        pr = rx_ready;
        pd = rx_data;
      end
    end
  end

  // Drives one frame; the expected outcome is queued before the first bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip,
                            input bit ready_at_stop, input bit aborted, output int start_cyc);
    logic sent_par;
    bit   par_bad;
    bit   takes;
    sent_par = (^b) ^ par_flip;
`ifdef UART_RX_PARITY_EN
    par_bad = ((^b) ^ sent_par) != 1'b0;
`else
    par_bad = 1'b0;
`endif
    takes = rx_ready || ready_at_stop;
    if (!aborted) begin
      if (par_bad) push_ev(K_PAR, 8'h00);
      if (!stop_bit) push_ev(K_FRAME, 8'h00);
      if (!par_bad && stop_bit) begin
        if (model_full && !takes) begin
          push_ev(K_OVR, 8'h00);
        end else begin
          push_ev(K_DATA, b);
          model_full = !takes;
        end
      end
    end
    @(posedge clk); #1;
    rx_pin = 1'b0;
    start_cyc = cyc;
    for (int k = 0; k < 8; k++) begin
      repeat (BIT_CLKS) @(posedge clk);
      #1 rx_pin = b[k];
    end
`ifdef UART_RX_PARITY_EN
    repeat (BIT_CLKS) @(posedge clk);
    #1 rx_pin = sent_par;
`endif
    repeat (BIT_CLKS) @(posedge clk);
    #1 rx_pin = stop_bit;
    if (ready_at_stop) begin
      repeat (10) @(posedge clk);
      #1 rx_ready = 1'b1;
      repeat (BIT_CLKS - 10) @(posedge clk);
    end else begin
      repeat (BIT_CLKS) @(posedge clk);
    end
    #1 rx_pin = 1'b1;
  endtask

  task automatic drain(string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int         s;
    int         d;
    int         gap;
    logic [7:0] rb;
    logic       sok;
    logic       pf;

    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_error", frame_error, 1'b0);
    check("reset_overrun_error", overrun_error, 1'b0);
    check("reset_parity_error", parity_error, 1'b0);
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // 0xA5 held, then released by rx_ready
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, s);
    check("a5_valid", rx_valid, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    d = last_pres_cyc - s - EXTRA_CLKS;
    check("a5_latency_in_window", (d >= 150 && d <= 158), 1'b1);
    rx_ready = 1'b1;
    model_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("a5_valid_drop", rx_valid, 1'b0);
    repeat (20) @(posedge clk);
    drain("drain_a5");

    // short glitch must be rejected, then a normal byte
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (40) @(posedge clk);
    drain("drain_glitch");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, s);
    repeat (10) @(posedge clk);
    drain("drain_3c");

    // framing error
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, s);
    repeat (32) @(posedge clk);
    check("frame_no_valid", rx_valid, 1'b0);
    drain("drain_frame");

    // overrun then same-clk accept+reload
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, s);
    repeat (10) @(posedge clk);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, s);
    repeat (10) @(posedge clk);
    check("overrun_keeps_old", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, s);
    repeat (20) @(posedge clk);
    check("reload_data", rx_data, 8'h22);
    drain("drain_overrun");

    // reset in the middle of bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, s);
      begin
        repeat (BIT_CLKS * 5 + 9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_frame_error", frame_error, 1'b0);
        check("midrst_overrun_error", overrun_error, 1'b0);
        check("midrst_parity_error", parity_error, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_full = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    drain("drain_midrst");
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, s);
    repeat (10) @(posedge clk);
    drain("drain_81");

    // break: one frame error only, then recovery
    push_ev(K_FRAME, 8'h00);
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (BIT_CLKS * 30) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (BIT_CLKS * 3) @(posedge clk);
    drain("drain_break");
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, s);
    repeat (10) @(posedge clk);
    drain("drain_5a");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, s);
    repeat (20) @(posedge clk);
    drain("drain_par_bad");
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, s);
    repeat (20) @(posedge clk);
    check("par_ok_data", rx_data, 8'h07);
    drain("drain_par_ok");
`endif

    // randomized frames with a draining consumer
    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      sok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      pf  = ($urandom_range(0, 4) == 0);
`else
      pf  = 1'b0;
`endif
      gap = $urandom_range(2, 20) + (sok ? 0 : BIT_CLKS);
      send_frame(rb, sok, pf, 1'b0, 1'b0, s);
      repeat (gap) @(posedge clk);
    end
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
